// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable-format UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic [1:0] BITS_5 = 2'd0;
    localparam logic [1:0] BITS_6 = 2'd1;
    localparam logic [1:0] BITS_7 = 2'd2;
    localparam logic [1:0] BITS_8 = 2'd3;

    function automatic logic par_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Input conditioning: optional 2-flop synchronizer, a run-length glitch filter
// and a falling-edge detector on the filtered level.
module glitch_filter #(
    parameter int   LEN               = 2,
    parameter logic RST_VAL           = 1'b0,
    parameter logic WITH_SYNCHRONIZER = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic sync_w;
    logic val_w;
    logic prev_q;

    genvar gi;
    generate
        if (WITH_SYNCHRONIZER) begin : g_sync
            logic [1:0] sync_q;
            for (gi = 0; gi < 2; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) sync_q[gi] <= RST_VAL;
                        else        sync_q[gi] <= din;
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) sync_q[gi] <= RST_VAL;
                        else        sync_q[gi] <= sync_q[gi-1];
                    end
                end
            end
            assign sync_w = sync_q[1];
        end else begin : g_nosync
            assign sync_w = din;
        end

        if (LEN == 0) begin : g_nofilt
            assign val_w = sync_w;
        end else begin : g_filt
            localparam int CW = (LEN < 2) ? 1 : $clog2(LEN);
            logic          val_q, val_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // The level only flips after LEN consecutive disagreeing samples.
            always_comb begin
                val_d = val_q;
                cnt_d = cnt_q;
                if (sync_w == val_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(LEN - 1)) begin
                    val_d = sync_w;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_q <= RST_VAL;
                    cnt_q <= '0;
                end else begin
                    val_q <= val_d;
                    cnt_q <= cnt_d;
                end
            end
            assign val_w = val_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= val_w;
    end

    assign dout = val_w;
    assign fall = prev_q & ~val_w;

endmodule

// File: rtl/uart_rx_fmt_baud_tick.sv
// Bit-timing generator: half-period preload on go, then full-period reloads,
// producing one tick per bit at the bit centre.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 active,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    localparam logic [DIV_WIDTH:0] ONE = {{DIV_WIDTH{1'b0}}, 1'b1};

    logic [DIV_WIDTH:0] cnt_q, cnt_d;

    // Reload with div+1 so consecutive ticks are div+2 clocks apart.
    always_comb begin
        tick  = active && (cnt_q == '0);
        cnt_d = cnt_q;
        if (go) begin
            cnt_d = {1'b0, div >> 1};
        end else if (tick) begin
            cnt_d = {1'b0, div} + ONE;
        end else if (active) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_fmt.sv
// Configurable-format UART receiver (5-8 data bits, N/E/O parity, 1-2 stop
// bits) with false-start rejection, per-frame status and an overrun-flagging output register.
module uart_rx_fmt
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH     = 8,
    parameter int GLITCH_FILTER = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           cfg_bits,
    input  logic [1:0]           cfg_par,
    input  logic                 cfg_stop2,
    output logic [7:0]           out_data,
    output logic                 out_perr,
    output logic                 out_ferr,
    output logic                 out_brk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovr_stb,
    output logic                 busy
);

    rx_state_t            state_q, state_d;
    logic [1:0]           bits_q, bits_d;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_perr_q, out_perr_d;
    logic                 out_ferr_q, out_ferr_d;
    logic                 out_brk_q, out_brk_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovr_q, ovr_d;

    logic                 rx_val, rx_fall;
    logic                 go, active, tick;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 last_bit, frame_done, par_en;
    logic                 ferr_now, brk_now, perr_now;

    glitch_filter #(
        .LEN              (GLITCH_FILTER),
        .RST_VAL          (1'b0),
        .WITH_SYNCHRONIZER(1'b1)
    ) u_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (rx),
        .dout (rx_val),
        .fall (rx_fall)
    );

    assign go      = (state_q == IDLE) && rx_fall;
    assign active  = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
    // The preload must see the live divisor on the go cycle; reloads use the latched copy.
    assign div_eff = go ? div : div_q;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .active(active),
        .div   (div_eff),
        .tick  (tick)
    );

    assign par_en     = par_enabled(par_q);
    assign last_bit   = (bit_cnt_q == (3'd4 + {1'b0, bits_q}));
    assign frame_done = (state_q == STOP) && tick && (!stop2_q || stop_cnt_q);
    assign ferr_now   = ferr_q | ~rx_val;
    assign brk_now    = ferr_now && (shift_q == 8'h00) && (!par_en || !par_bit_q);
    assign perr_now   = par_en && ((^shift_q ^ par_bit_q) != (par_q == PAR_ODD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bits_q      <= '0;
            par_q       <= '0;
            stop2_q     <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            ferr_q      <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            out_ferr_q  <= 1'b0;
            out_brk_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_q      <= bits_d;
            par_q       <= par_d;
            stop2_q     <= stop2_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            ferr_q      <= ferr_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            out_ferr_q  <= out_ferr_d;
            out_brk_q   <= out_brk_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (rx_fall) state_d = START;
            START:     if (tick) state_d = rx_val ? IDLE : DATA;
            DATA:      if (tick && last_bit) state_d = par_en ? PARITY : STOP;
            PARITY:    if (tick) state_d = STOP;
            // Leaving at the last stop-tick centre lets a start edge half a bit later re-arm.
            STOP:      if (frame_done) state_d = brk_now ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (rx_val) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bits_d      = bits_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        ferr_d      = ferr_q;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        out_ferr_d  = out_ferr_q;
        out_brk_d   = out_brk_q;
        out_valid_d = out_valid_q;
        ovr_d       = 1'b0;

        if (go) begin
            bits_d     = cfg_bits;
            par_d      = cfg_par;
            stop2_d    = cfg_stop2;
            div_d      = div;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            shift_d    = '0;
            par_bit_d  = 1'b0;
            ferr_d     = 1'b0;
        end

        if (tick) begin
            case (state_q)
                DATA: begin
                    shift_d[bit_cnt_q] = rx_val;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                end
                PARITY: par_bit_d = rx_val;
                STOP: begin
                    ferr_d     = ferr_now;
                    stop_cnt_d = 1'b1;
                end
                default: ;
            endcase
        end

        // A completion during a handshake replaces the word; otherwise it is dropped.
        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_perr_d  = perr_now;
                out_ferr_d  = ferr_now;
                out_brk_d   = brk_now;
                out_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;
    assign out_ferr  = out_ferr_q;
    assign out_brk   = out_brk_q;
    assign out_valid = out_valid_q;
    assign ovr_stb   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule
